// File: rtl/power_sense_monitor.sv
// Avalon-MM power-sense supervisor: per-line 2-flop sync, debounce, qualified
// edge capture (write-1-to-clear) and a registered, maskable level interrupt.
module power_sense_monitor #(
  parameter int WIDTH           = 6,
  parameter int DEBOUNCE_CYCLES = 1000,
  parameter int CNT_W           = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [1:0]       address,
  input  logic             read,
  input  logic             write,
  input  logic [31:0]      writedata,
  output logic [31:0]      readdata,
  input  logic [WIDTH-1:0] in_port,
  output logic             irq
);

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  typedef enum logic [1:0] {
    ADDR_DATA = 2'd0,
    ADDR_MASK = 2'd1,
    ADDR_EDGE = 2'd2,
    ADDR_CTRL = 2'd3
  } addr_e;

  logic [WIDTH-1:0] s1, s2, deb;
  logic [WIDTH-1:0] edge_capture, irq_mask;
  logic [2:0]       ctrl;
  logic [CNT_W-1:0] cnt [WIDTH];
  logic [1:0]       prime_cnt;
  logic             primed;

  logic [WIDTH-1:0] hit, rise_ev, fall_ev, qual, w1c;
  logic [31:0]      rd_mux;
  logic             unused_bits;

  // A line "hits" when its changed level has persisted for the full window.
  always_comb begin
    hit = '0;
    for (int i = 0; i < WIDTH; i++) begin
      hit[i] = primed && (s2[i] != deb[i]) && (cnt[i] == CNT_LAST);
    end
  end

  assign rise_ev = hit & s2;
  assign fall_ev = hit & ~s2;
  assign qual    = ctrl[0] ? ((rise_ev & {WIDTH{ctrl[1]}}) | (fall_ev & {WIDTH{ctrl[2]}}))
                           : '0;
  assign w1c     = (write && address == ADDR_EDGE) ? writedata[WIDTH-1:0] : '0;
  assign unused_bits = ^writedata;

  always_comb begin
    rd_mux = '0;
    case (addr_e'(address))
      ADDR_DATA: rd_mux[WIDTH-1:0] = deb;
      ADDR_MASK: rd_mux[WIDTH-1:0] = irq_mask;
      ADDR_EDGE: rd_mux[WIDTH-1:0] = edge_capture;
      ADDR_CTRL: rd_mux[2:0]       = ctrl;
      default:   rd_mux            = '0;
    endcase
  end

  // NOTE: the per-line counters are a handful of flops, not a RAM, so they are
  // reset like any other state; a mid-debounce reset must discard every count.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      s1        <= '0;
      s2        <= '0;
      deb       <= '0;
      prime_cnt <= '0;
      primed    <= 1'b0;
      for (int i = 0; i < WIDTH; i++) cnt[i] <= '0;
    end else begin
      s1 <= in_port;
      s2 <= s1;
      if (!primed) begin
        if (prime_cnt == 2'd2) begin
          primed <= 1'b1;
          deb    <= s2;
        end else begin
          prime_cnt <= prime_cnt + 2'd1;
        end
      end else begin
        deb <= (deb & ~hit) | (s2 & hit);
      end
      for (int i = 0; i < WIDTH; i++) begin
        if (!primed || s2[i] == deb[i] || hit[i]) cnt[i] <= '0;
        else                                      cnt[i] <= cnt[i] + CNT_W'(1);
      end
    end
  end

  // Set has priority over a same-cycle write-1-to-clear on the same bit.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      edge_capture <= '0;
      irq_mask     <= '0;
      ctrl         <= '0;
      readdata     <= '0;
      irq          <= 1'b0;
    end else begin
      edge_capture <= (edge_capture & ~w1c) | qual;
      if (write && address == ADDR_MASK) irq_mask <= writedata[WIDTH-1:0];
      if (write && address == ADDR_CTRL) ctrl     <= writedata[2:0];
      if (read) readdata <= rd_mux;
      irq <= |(edge_capture & irq_mask);
    end
  end

endmodule

// File: tb/tb_power_sense_monitor.sv
// Scoreboarded bench for power_sense_monitor (WIDTH=6, DEBOUNCE_CYCLES=4).
module tb_power_sense_monitor;

  logic        clk = 1'b0;
  logic        reset;
  logic [1:0]  address;
  logic        read, write;
  logic [31:0] writedata;
  logic [31:0] readdata;
  logic [5:0]  in_port;
  logic        irq;

  int total = 0;
  int bad   = 0;

  typedef struct {
    string       tag;
    logic [31:0] exp;
  } exp_t;

  exp_t sb[$];

  power_sense_monitor #(.WIDTH(6), .DEBOUNCE_CYCLES(4), .CNT_W(16)) dut (
    .clk(clk), .reset(reset), .address(address), .read(read), .write(write),
    .writedata(writedata), .readdata(readdata), .in_port(in_port), .irq(irq)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
    end
  endtask

  // Each read is sampled at the posedge; readdata is compared 1 time unit later.
  initial begin
    forever begin
      @(posedge clk);
      if (read === 1'b1 && reset === 1'b0) begin
        #1;
        if (sb.size() == 0) begin
          check("sb_underflow", 32'(sb.size()), 32'd1);
        end else begin
          exp_t e;
          e = sb.pop_front();
          check(e.tag, readdata, e.exp);
        end
      end
    end
  end

  // All bus tasks start and end on a negedge and occupy exactly one cycle.
  task automatic do_read(input logic [1:0] a, input logic [31:0] exp, input string tag);
    address = a;
    read    = 1'b1;
    sb.push_back('{tag, exp});
    @(negedge clk);
    read = 1'b0;
  endtask

  task automatic do_write(input logic [1:0] a, input logic [31:0] d);
    address   = a;
    writedata = d;
    write     = 1'b1;
    @(negedge clk);
    write = 1'b0;
  endtask

  task automatic do_rw(input logic [1:0] a, input logic [31:0] d, input logic [31:0] exp,
                       input string tag);
    address   = a;
    writedata = d;
    write     = 1'b1;
    read      = 1'b1;
    sb.push_back('{tag, exp});
    @(negedge clk);
    write = 1'b0;
    read  = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  initial begin
    reset = 1'b1; address = '0; read = 1'b0; write = 1'b0; writedata = '0;
    in_port = 6'b101010;
    idle(3);
    check("rst_readdata", readdata, 32'h0);
    check("rst_irq", 32'(irq), 32'h0);

    // Priming: deb loads from s2 on the 3rd edge after release.
    reset = 1'b0;
    idle(2);
    do_read(0, 32'h00, "prime_before");
    do_read(0, 32'h2A, "prime_data");
    do_read(2, 32'h00, "prime_edge");
    check("prime_irq", 32'(irq), 32'h0);
    do_read(3, 32'h00, "rst_ctrl");
    do_read(1, 32'h00, "rst_mask");
    do_write(0, 32'h3F);
    do_read(0, 32'h2A, "data_ro");
    do_rw(1, 32'h15, 32'h00, "rw_prewrite");
    do_read(1, 32'h15, "rw_mask");

    // Return all lines low with qualification off.
    in_port = 6'h00;
    idle(10);
    do_read(0, 32'h00, "idle_data");
    do_read(2, 32'h00, "disabled_edge");
    do_write(3, 32'h7);
    do_write(1, 32'h3F);

    // Glitch of 3 cycles on bit0 is rejected.
    in_port = 6'h01;
    idle(3);
    in_port = 6'h00;
    idle(8);
    do_read(0, 32'h00, "glitch_data");
    do_read(2, 32'h00, "glitch_edge");
    check("glitch_irq", 32'(irq), 32'h0);

    // Rise on bit0: deb flips on the 6th edge, irq one edge later.
    in_port = 6'h01;
    idle(5);
    do_read(0, 32'h00, "rise_edge5");
    check("rise_irq_lag", 32'(irq), 32'h0);
    do_read(0, 32'h01, "rise_data");
    check("rise_irq", 32'(irq), 32'h1);
    do_read(2, 32'h01, "rise_capture");
    do_write(2, 32'h01);
    check("w1c_irq_hold", 32'(irq), 32'h1);
    @(negedge clk);
    check("w1c_irq", 32'(irq), 32'h0);
    do_read(2, 32'h00, "w1c_edge");

    // Fall-only polarity with mask on bit2.
    do_write(3, 32'h5);
    do_write(1, 32'h04);
    in_port = 6'h05;
    idle(10);
    do_read(2, 32'h00, "pol_rise_ignored");
    in_port = 6'h01;
    idle(10);
    do_read(2, 32'h04, "pol_fall_capture");
    check("pol_irq", 32'(irq), 32'h1);
    do_write(2, 32'h04);
    do_write(1, 32'h00);
    in_port = 6'h05;
    idle(10);
    in_port = 6'h01;
    idle(10);
    do_read(2, 32'h04, "masked_capture");
    check("masked_irq", 32'(irq), 32'h0);
    do_write(2, 32'h04);

    // W1C of bit3 lands on the same edge as its rise event: set wins.
    do_write(3, 32'h7);
    in_port = 6'h09;
    idle(5);
    do_write(2, 32'h08);
    do_read(2, 32'h08, "collision_set_wins");
    do_read(0, 32'h09, "collision_data");

    // Reset while bit1 change is mid-debounce.
    in_port = 6'h0B;
    idle(4);
    reset = 1'b1;
    #1;
    check("midrst_readdata", readdata, 32'h0);
    check("midrst_irq", 32'(irq), 32'h0);
    idle(2);
    reset = 1'b0;
    idle(2);
    do_read(0, 32'h00, "reprime_before");
    do_read(0, 32'h0B, "reprime_data");
    do_read(2, 32'h00, "reprime_edge");
    do_read(3, 32'h00, "reprime_ctrl");
    do_write(3, 32'h7);
    idle(10);
    do_read(2, 32'h00, "reprime_no_edge");
    do_read(0, 32'h0B, "reprime_stable");

    idle(2);
    check("sb_drain", 32'(sb.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
